// File: rtl/bus_arbiter_if.sv
// Requester-side and memory-side signals of the three-port bus arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus memory.
interface bus_arbiter_if;
  logic [2:0]  req;
  logic [2:0]  rw;
  logic [95:0] addr;
  logic [95:0] wdata;
  logic [2:0]  ack;
  logic [2:0]  err;
  logic [31:0] rdata;
  logic [1:0]  grant;
  logic        m_strobe;
  logic        m_rw;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;

  modport slave (
    input  req, rw, addr, wdata, m_rdata, m_ready,
    output ack, err, rdata, grant, m_strobe, m_rw, m_addr, m_wdata
  );

  modport master (
    output req, rw, addr, wdata, m_rdata, m_ready,
    input  ack, err, rdata, grant, m_strobe, m_rw, m_addr, m_wdata
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter granting one of three ports a single memory access, with a
// bounded wait for memory completion; every output is driven from a register.
module bus_arbiter #(
  parameter int TIMEOUT = 16
) (
  input logic          clk,
  input logic          reset_n,
  bus_arbiter_if.slave bus
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [1:0]  grant_r, grant_nxt_s;
  logic [1:0]  last_r, last_nxt_s;
  logic [1:0]  win_s;
  logic [7:0]  cnt_r, cnt_nxt_s;
  logic [2:0]  ack_r, ack_nxt_s;
  logic [2:0]  err_r, err_nxt_s;
  logic [2:0]  gnt_onehot_s;
  logic [31:0] rdata_r, rdata_nxt_s;
  logic [31:0] m_addr_r, m_addr_nxt_s;
  logic [31:0] m_wdata_r, m_wdata_nxt_s;
  logic        m_strobe_r, m_strobe_nxt_s;
  logic        m_rw_r, m_rw_nxt_s;
  logic        wait_done_s;

  // Search order after `last_v`: last+1, last+2, then last itself.
  function automatic logic [1:0] rr_pick(input logic [2:0] req_v, input logic [1:0] last_v);
    logic [1:0] first_v, second_v, third_v, pick_v;
    case (last_v)
      2'd0: begin first_v = 2'd1; second_v = 2'd2; third_v = 2'd0; end
      2'd1: begin first_v = 2'd2; second_v = 2'd0; third_v = 2'd1; end
      default: begin first_v = 2'd0; second_v = 2'd1; third_v = 2'd2; end
    endcase
    if (req_v[first_v]) begin
      pick_v = first_v;
    end else if (req_v[second_v]) begin
      pick_v = second_v;
    end else begin
      pick_v = third_v;
    end
    return pick_v;
  endfunction

  function automatic logic [31:0] lane(input logic [95:0] vec, input logic [1:0] idx);
    logic [31:0] r_v;
    case (idx)
      2'd0:    r_v = vec[31:0];
      2'd1:    r_v = vec[63:32];
      2'd2:    r_v = vec[95:64];
      default: r_v = 32'd0;
    endcase
    return r_v;
  endfunction

  assign win_s        = rr_pick(bus.req, last_r);
  assign gnt_onehot_s = 3'b001 << grant_r;
  assign wait_done_s  = bus.m_ready | (cnt_r == TIMEOUT_C);

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      grant_r    <= 2'd3;
      last_r     <= 2'd2;
      cnt_r      <= 8'd0;
      ack_r      <= 3'b000;
      err_r      <= 3'b000;
      rdata_r    <= 32'd0;
      m_strobe_r <= 1'b0;
      m_rw_r     <= 1'b0;
      m_addr_r   <= 32'd0;
      m_wdata_r  <= 32'd0;
    end else begin
      state_r    <= state_nxt_s;
      grant_r    <= grant_nxt_s;
      last_r     <= last_nxt_s;
      cnt_r      <= cnt_nxt_s;
      ack_r      <= ack_nxt_s;
      err_r      <= err_nxt_s;
      rdata_r    <= rdata_nxt_s;
      m_strobe_r <= m_strobe_nxt_s;
      m_rw_r     <= m_rw_nxt_s;
      m_addr_r   <= m_addr_nxt_s;
      m_wdata_r  <= m_wdata_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (|bus.req) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: state_nxt_s = WAIT;
      WAIT: begin
        if (wait_done_s) begin
          state_nxt_s = ACK;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      ACK:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the output registers; m_ready outside WAIT is never looked at.
  always_comb begin
    grant_nxt_s    = grant_r;
    last_nxt_s     = last_r;
    cnt_nxt_s      = cnt_r;
    ack_nxt_s      = 3'b000;
    err_nxt_s      = 3'b000;
    rdata_nxt_s    = rdata_r;
    m_strobe_nxt_s = 1'b0;
    m_rw_nxt_s     = m_rw_r;
    m_addr_nxt_s   = m_addr_r;
    m_wdata_nxt_s  = m_wdata_r;
    case (state_r)
      IDLE: begin
        if (|bus.req) begin
          grant_nxt_s    = win_s;
          m_strobe_nxt_s = 1'b1;
          m_rw_nxt_s     = bus.rw[win_s];
          m_addr_nxt_s   = lane(bus.addr, win_s);
          m_wdata_nxt_s  = lane(bus.wdata, win_s);
        end else begin
          grant_nxt_s = 2'd3;
        end
      end
      ISSUE: cnt_nxt_s = 8'd1;
      WAIT: begin
        if (wait_done_s) begin
          cnt_nxt_s     = 8'd0;
          ack_nxt_s     = gnt_onehot_s;
          m_rw_nxt_s    = 1'b0;
          m_addr_nxt_s  = 32'd0;
          m_wdata_nxt_s = 32'd0;
          // A completion on the final count still counts as success.
          if (bus.m_ready) begin
            rdata_nxt_s = m_rw_r ? 32'd0 : bus.m_rdata;
          end else begin
            err_nxt_s   = gnt_onehot_s;
            rdata_nxt_s = 32'd0;
          end
        end else begin
          cnt_nxt_s = cnt_r + 8'd1;
        end
      end
      ACK: begin
        last_nxt_s  = grant_r;
        grant_nxt_s = 2'd3;
      end
      default: grant_nxt_s = 2'd3;
    endcase
  end

  assign bus.ack      = ack_r;
  assign bus.err      = err_r;
  assign bus.rdata    = rdata_r;
  assign bus.grant    = grant_r;
  assign bus.m_strobe = m_strobe_r;
  assign bus.m_rw     = m_rw_r;
  assign bus.m_addr   = m_addr_r;
  assign bus.m_wdata  = m_wdata_r;

endmodule
